// File: rtl/dino_pkg.sv
// Shared types and constants for the dinosaur-game obstacle logic.
// Holds the obstacle kinds, scheduler states and the LFSR feedback function.
package dino_pkg;

    localparam int             LFSR_W    = 5;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

    typedef enum logic [1:0] {
        SMALL  = 2'd0,
        DOUBLE = 2'd1,
        LARGE  = 2'd2,
        BIRD   = 2'd3
    } obstacle_kind_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP   = 3'd1,
        S_DRAW  = 3'd2,
        S_HOLD  = 3'd3,
        S_OFFER = 3'd4
    } sched_state_t;

    // Taps at bits 4 and 1 give a maximal-length sequence that never hits zero.
    function automatic logic [LFSR_W-1:0] lfsr5_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], q[1] ^ q[4]};
    endfunction

endpackage

// File: rtl/dino_lfsr5.sv
// 5-bit LFSR register for obstacle randomness; advances one step when step is high.
module dino_lfsr5
    import dino_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= LFSR_SEED;
        else if (step)
            q <= lfsr5_next(q);
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Spawn scheduler: times obstacle gaps, draws a random kind and offers it to the renderer.
// Define OBS_BIRD_EN to map LFSR kind bits 11 to BIRD instead of DOUBLE.
//
// state   | meaning
// IDLE    | game not running; gap and on-screen count cleared
// GAP     | counting down frame ticks until the next spawn
// DRAW    | step LFSR, latch obstacle kind
// HOLD    | screen full; wait for a retire
// OFFER   | spawn_valid high until the renderer takes it
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int MIN_GAP   = 40,
    parameter int GAP_SHIFT = 1,
    parameter int MAX_OBS   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        frame_tick,
    input  logic        seed_event,
    input  logic        obs_retire,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic [1:0]  spawn_kind,
    output logic [1:0]  active_count,
    output logic [4:0]  lfsr_q
);

    localparam logic [1:0] MAX_OBS_C = 2'(MAX_OBS);

    sched_state_t   state, state_next;
    obstacle_kind_t kind_q, kind_draw;
    logic [7:0]     gap_cnt, gap_val;
    logic [15:0]    gap_sum;
    logic [LFSR_W-1:0] lfsr_stepped;
    logic           handshake, has_room, draw, lfsr_step, load_gap;
    logic           cnt_inc, cnt_dec;

    function automatic obstacle_kind_t kind_of(input logic [LFSR_W-1:0] v);
        case (v[1:0])
            2'b10:   return LARGE;
`ifdef OBS_BIRD_EN
            2'b11:   return BIRD;
`else
            2'b11:   return DOUBLE;
`endif
            default: return SMALL;
        endcase
    endfunction

    dino_lfsr5 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    assign handshake    = spawn_valid & spawn_ready;
    assign has_room     = active_count < MAX_OBS_C;
    assign lfsr_stepped = lfsr5_next(lfsr_q);
    assign gap_sum      = 16'(MIN_GAP) + (16'(lfsr_q) << GAP_SHIFT);
    assign gap_val      = (gap_sum > 16'd255) ? 8'hFF : gap_sum[7:0];
    assign spawn_kind   = kind_q;

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!run) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_next = S_GAP;
                S_GAP:   if (frame_tick && gap_cnt == 8'd1) state_next = S_DRAW;
                S_DRAW:  state_next = has_room ? S_OFFER : S_HOLD;
                S_HOLD:  if (has_room) state_next = S_OFFER;
                S_OFFER: if (handshake) state_next = S_GAP;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // DRAW owns the LFSR step in its cycle, so a coincident seed_event adds nothing.
    always_comb begin
        draw      = (state == S_DRAW);
        lfsr_step = draw | seed_event;
        load_gap  = (state == S_IDLE) | handshake;
        kind_draw = kind_of(lfsr_stepped);
        cnt_inc   = handshake & has_room;
        cnt_dec   = obs_retire & (active_count != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spawn_valid  <= 1'b0;
            kind_q       <= SMALL;
            active_count <= 2'd0;
            gap_cnt      <= 8'd0;
        end else begin
            spawn_valid <= (state_next == S_OFFER);
            if (draw)
                kind_q <= kind_draw;
            if (state_next == S_IDLE) begin
                active_count <= 2'd0;
                gap_cnt      <= 8'd0;
            end else begin
                if (load_gap)
                    gap_cnt <= gap_val;
                else if (state == S_GAP && frame_tick)
                    gap_cnt <= gap_cnt - 8'd1;
                case ({cnt_inc, cnt_dec})
                    2'b10:   active_count <= active_count + 2'd1;
                    2'b01:   active_count <= active_count - 2'd1;
                    default: active_count <= active_count;
                endcase
            end
        end
    end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Decides when and which cactus/obstacle to spawn in the dinosaur game. It owns a 5-bit LFSR random source. It steps the LFSR once per spawn decision and stirs it on player jump presses. It times the gap between obstacles in frames and offers each new obstacle to the obstacle renderer over a valid/ready handshake. It sits between the frame-tick generator and game-state FSM on one side and the obstacle draw/collision logic on the other.

## Interface
- MIN_GAP, 40, minimum frames between spawns; must be ≥1
- GAP_SHIFT, 1, left shift applied to the LFSR value when added to MIN_GAP
- MAX_OBS, 3, maximum obstacles on screen at once (1..3)
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- run  in  1  game running; low = game over/attract
- frame_tick  in  1  one-cycle pulse per video frame
- seed_event  in  1  one-cycle pulse on jump press; stirs the LFSR
- obs_retire  in  1  one-cycle pulse when an obstacle leaves the screen
- spawn_ready  in  1  renderer can accept an obstacle
- spawn_valid  out  1  spawn request pending
- spawn_kind  out  2  obstacle type, stable while spawn_valid
- active_count  out  2  obstacles currently on screen
- lfsr_q  out  5  current LFSR state (debug/visible)

## Operation
- LFSR: 5 bits. Shift toward the MSB; new bit[0] = bit[1] ^ bit[4]. Reset value 5'b00001. The all-zero state is never reached.
- The LFSR steps at most once per cycle. A DRAW step has priority: a seed_event in the same cycle is dropped. Otherwise each seed_event steps it once, in any state including IDLE.
- Gap: 8-bit value MIN_GAP + (lfsr_q << GAP_SHIFT), computed from lfsr_q when loaded. Saturates at 255.
- FSM states and transitions:
  - IDLE: gap counter = 0, active_count = 0. When run = 1, load the gap and go to GAP.
  - GAP: on each frame_tick, if count == 1 go to DRAW, else count−1. Non-tick cycles hold the count.
  - DRAW: one cycle. Step the LFSR. Latch spawn_kind from bits[1:0] of the stepped value. Go to OFFER if active_count < MAX_OBS, else go to HOLD.
  - HOLD: wait for active_count < MAX_OBS, then go to OFFER. frame_ticks are ignored.
  - OFFER: spawn_valid = 1 until spawn_ready. On the handshake cycle: active_count+1, load the new gap from the current lfsr_q, go to GAP.
- run low in any state: go to IDLE the next cycle. spawn_valid drops that same next cycle.
- Kind map: 00 and 01 → SMALL (0), 10 → LARGE (2), 11 → see Configuration.
- active_count:
  - Spawn handshake and obs_retire in the same cycle leave it unchanged.
  - obs_retire at 0 is ignored.
  - It never exceeds MAX_OBS.

## Timing
- Reset values:
  - spawn_valid 0
  - spawn_kind 0
  - active_count 0
  - lfsr_q 5'b00001
  - state IDLE
- All outputs are registered.
- Gap N: DRAW is entered the cycle after the N-th frame_tick following the load. spawn_valid asserts the cycle after DRAW.
- Handshake completes on any cycle where spawn_valid & spawn_ready. spawn_valid deasserts the next cycle. spawn_kind is held until then.
- A renderer that never asserts spawn_ready stalls the FSM in OFFER indefinitely. No timeout.
- Reset mid-operation (any state, including OFFER) returns to reset values the next cycle. Any pending offer is abandoned.

## Configuration
- OBS_BIRD_EN defined: kind 11 → BIRD (3), a flying obstacle.
- OBS_BIRD_EN undefined: kind 11 → DOUBLE (1), a cactus pair. BIRD is never emitted.
- The gap arithmetic and FSM are identical in both builds.

## Structure
- Shared package dino_pkg:
  - obstacle_kind_t enum: SMALL = 0, DOUBLE = 1, LARGE = 2, BIRD = 3
  - LFSR width and reset-seed constants
  - sched_state_t enum
- One sub-module, dino_lfsr5. Ports: clk, reset, step, q[4:0]. It holds only the LFSR register and feedback. Priority muxing of the step sources stays in obstacle_scheduler.

## Test plan
- Reset, run = 1, MIN_GAP = 4, GAP_SHIFT = 0, spawn_ready = 1 → gap 5. spawn_valid rises 2 cycles after the 5th frame_tick. lfsr_q = 5'b00010, spawn_kind = LARGE. Next gap = 6.
- Three spawns, no retire, MAX_OBS = 3 → active_count = 3. The 4th DRAW goes to HOLD. An obs_retire pulse → spawn_valid next-next cycle, active_count returns to 3.
- spawn_ready = 0 for 10 cycles during OFFER → spawn_valid and spawn_kind stable for all 10. On ready: exactly one increment.
- seed_event and DRAW in the same cycle → lfsr_q advances exactly one step. seed_event in IDLE from 5'b00001 → 5'b00010.
- obs_retire coincident with handshake at active_count = 2 → stays 2. obs_retire at 0 → stays 0.
- run dropped during OFFER → spawn_valid 0 the next cycle, active_count 0, state IDLE. Repeat with reset instead → all reset values. Run in both OBS_BIRD_EN builds and check the kind-11 mapping.
